// File: rtl/vx_kmu_dispatch.sv
// Kernel-launch task dispatcher.
// Accepts one launch, walks the block grid (x fastest, then y, then z) and
// emits one task per block. Issue is throttled on an outstanding-task limit,
// and a completion pulse follows once every issued block has retired.
module vx_kmu_dispatch #(
   parameter int XLEN        = 32,
   parameter int DIM_W       = 16,
   parameter int MAX_PENDING = 64,
   parameter int PEND_W      = $clog2(MAX_PENDING + 1)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start_valid,
   output logic               start_ready,
   input  logic [XLEN-1:0]    start_pc,
   input  logic [XLEN-1:0]    start_param,
   input  logic [3*DIM_W-1:0] grid_dim,
   input  logic [3*DIM_W-1:0] block_dim,
   output logic               task_valid,
   input  logic               task_ready,
   output logic [XLEN-1:0]    task_pc,
   output logic [XLEN-1:0]    task_param,
   output logic [3*DIM_W-1:0] task_block_idx,
   output logic [3*DIM_W-1:0] task_block_dim,
   output logic               task_last,
   input  logic               task_done,
   output logic               busy,
   output logic               kernel_done,
   output logic               err_underflow
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_FIN   = 2'd3;

   logic [1:0]          r_state;
   logic                r_valid;
   logic                r_err;
   logic [PEND_W-1:0]   r_pend;
   logic [XLEN-1:0]     r_pc;
   logic [XLEN-1:0]     r_param;
   logic [3*DIM_W-1:0]  r_grid;
   logic [3*DIM_W-1:0]  r_bdim;
   logic [DIM_W-1:0]    r_ix;
   logic [DIM_W-1:0]    r_iy;
   logic [DIM_W-1:0]    r_iz;

   logic [1:0]          w_state_nxt;
   logic [PEND_W-1:0]   w_pend_nxt;
   logic                w_unf;
   logic                w_hs;
   logic                w_start;
   logic                w_grid_zero;
   logic                w_x_end;
   logic                w_y_end;
   logic                w_z_end;
   logic                w_last;
   logic                w_valid_nxt;

   assign w_hs        = r_valid & task_ready;
   assign w_start     = start_valid & (r_state == S_IDLE);
   assign w_grid_zero = (grid_dim[DIM_W-1:0] == '0) ||
                        (grid_dim[2*DIM_W-1:DIM_W] == '0) ||
                        (grid_dim[3*DIM_W-1:2*DIM_W] == '0);

   // Wrap points are g-1, so an index never needs to reach the grid size.
   assign w_x_end = (r_ix == r_grid[DIM_W-1:0] - DIM_W'(1));
   assign w_y_end = (r_iy == r_grid[2*DIM_W-1:DIM_W] - DIM_W'(1));
   assign w_z_end = (r_iz == r_grid[3*DIM_W-1:2*DIM_W] - DIM_W'(1));
   assign w_last  = w_x_end & w_y_end & w_z_end;

   // Outstanding count: a same-cycle issue and retire cancel; a retire with
   // nothing outstanding is held at zero and flagged.
   always_comb begin
      w_pend_nxt = r_pend;
      w_unf      = 1'b0;
      if (w_hs && !task_done) begin
         w_pend_nxt = r_pend + PEND_W'(1);
      end else if (!w_hs && task_done) begin
         if (r_pend == '0) w_unf = 1'b1;
         else              w_pend_nxt = r_pend - PEND_W'(1);
      end
   end

   // Launch sequencing: IDLE -> ISSUE -> DRAIN -> FIN, empty grids skip to FIN.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_state_nxt = w_grid_zero ? S_FIN : S_ISSUE;
         S_ISSUE: if (w_hs && w_last) w_state_nxt = S_DRAIN;
         S_DRAIN: if (w_pend_nxt == '0) w_state_nxt = S_FIN;
         S_FIN:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Valid is registered from next-cycle state and count, so it is gated
   // before assertion and never withdrawn while a handshake is pending.
   assign w_valid_nxt = (w_state_nxt == S_ISSUE) &&
                        (w_pend_nxt < PEND_W'(MAX_PENDING));

   // Control state, outstanding counter and sticky underflow flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_valid <= 1'b0;
         r_pend  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_valid <= w_valid_nxt;
         r_pend  <= w_pend_nxt;
         if (w_unf) r_err <= 1'b1;
      end
   end

   // Launch fields and grid walk; the index only moves on a handshake.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pc    <= '0;
         r_param <= '0;
         r_grid  <= '0;
         r_bdim  <= '0;
         r_ix    <= '0;
         r_iy    <= '0;
         r_iz    <= '0;
      end else if (w_start) begin
         r_pc    <= start_pc;
         r_param <= start_param;
         r_grid  <= grid_dim;
         r_bdim  <= block_dim;
         r_ix    <= '0;
         r_iy    <= '0;
         r_iz    <= '0;
      end else if (w_hs && !w_last) begin
         if (w_x_end) begin
            r_ix <= '0;
            if (w_y_end) begin
               r_iy <= '0;
               r_iz <= r_iz + DIM_W'(1);
            end else begin
               r_iy <= r_iy + DIM_W'(1);
            end
         end else begin
            r_ix <= r_ix + DIM_W'(1);
         end
      end
   end

   assign start_ready    = (r_state == S_IDLE);
   assign busy           = (r_state == S_ISSUE) || (r_state == S_DRAIN);
   assign kernel_done    = (r_state == S_FIN);
   assign err_underflow  = r_err;
   assign task_valid     = r_valid;
   assign task_last      = r_valid & w_last;
   assign task_pc        = r_pc;
   assign task_param     = r_param;
   assign task_block_dim = r_bdim;
   assign task_block_idx = {r_iz, r_iy, r_ix};

endmodule

// File: tb/tb_vx_kmu_dispatch.sv
// Bench for vx_kmu_dispatch: a queue-based launch model predicts every
// cycle's outputs; directed launches pin a few literal expectations.
module tb_vx_kmu_dispatch;
   localparam int XLEN  = 32;
   localparam int DIM_W = 16;
   localparam int MP    = 2;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               start_valid = 1'b0;
   logic               start_ready;
   logic [XLEN-1:0]    start_pc = '0;
   logic [XLEN-1:0]    start_param = '0;
   logic [3*DIM_W-1:0] grid_dim = '0;
   logic [3*DIM_W-1:0] block_dim = '0;
   logic               task_valid;
   logic               task_ready = 1'b0;
   logic [XLEN-1:0]    task_pc;
   logic [XLEN-1:0]    task_param;
   logic [3*DIM_W-1:0] task_block_idx;
   logic [3*DIM_W-1:0] task_block_dim;
   logic               task_last;
   logic               task_done = 1'b0;
   logic               busy;
   logic               kernel_done;
   logic               err_underflow;

   vx_kmu_dispatch #(.XLEN(XLEN), .DIM_W(DIM_W), .MAX_PENDING(MP)) dut (
      .clk(clk), .reset_n(reset_n),
      .start_valid(start_valid), .start_ready(start_ready),
      .start_pc(start_pc), .start_param(start_param),
      .grid_dim(grid_dim), .block_dim(block_dim),
      .task_valid(task_valid), .task_ready(task_ready),
      .task_pc(task_pc), .task_param(task_param),
      .task_block_idx(task_block_idx), .task_block_dim(task_block_dim),
      .task_last(task_last), .task_done(task_done),
      .busy(busy), .kernel_done(kernel_done), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // stimulus controls (written by the main process only)
   int  rmode = 0;      // 0 always ready, 1 pattern 1,0,0, 2 random
   int  dmode = 0;      // 0 retire whenever pending, 1 never, 2 random
   bit  noise = 1'b0;   // stray start_valid while a launch is active
   bit  drv_en = 1'b0;
   bit  force_done = 1'b0;
   int  req_seq = 0;
   int  req_gz, req_gy, req_gx;

   // model state (written by the compare process only)
   bit               m_active = 1'b0;
   int               m_pend = 0;
   bit               m_err = 1'b0;
   logic [XLEN-1:0]  m_pc, m_param;
   logic [3*DIM_W-1:0] m_bdim;
   logic [3*DIM_W-1:0] m_q[$];
   logic [3*DIM_W-1:0] got[$];
   int               n_hs = 0;
   int               n_kd = 0;
   int               last_hs = 0;
   bit               e_valid, e_kd, hs;

   // Input driver, just after each rising edge.
   int ack_seq = 0;
   int rcnt = 0;
   always @(posedge clk) begin
      #1;
      if (!drv_en) begin
         start_valid = 1'b0;
         task_ready  = 1'b0;
         task_done   = 1'b0;
      end else begin
         rcnt++;
         case (rmode)
            0:       task_ready = 1'b1;
            1:       task_ready = (rcnt % 3 == 0);
            default: task_ready = 1'($urandom_range(0, 1));
         endcase
         if (force_done) task_done = 1'b1;
         else if (m_pend > 0)
            case (dmode)
               0:       task_done = 1'b1;
               1:       task_done = 1'b0;
               default: task_done = 1'($urandom_range(0, 1));
            endcase
         else task_done = 1'b0;
         if (req_seq != ack_seq && !m_active) begin
            ack_seq     = req_seq;
            start_valid = 1'b1;
            start_pc    = $urandom;
            start_param = $urandom;
            block_dim   = {16'($urandom), 16'($urandom), 16'($urandom)};
            grid_dim    = {16'(req_gz), 16'(req_gy), 16'(req_gx)};
         end else begin
            start_valid = noise && m_active && ($urandom_range(0, 3) == 0);
            grid_dim    = {16'($urandom_range(0, 2)), 16'($urandom_range(0, 2)), 16'($urandom_range(0, 2))};
         end
      end
   end

   // Reference model and per-cycle compare, on the falling edge.
   always @(negedge clk) begin
      if (!reset_n) begin
         m_active = 1'b0;
         m_pend   = 0;
         m_err    = 1'b0;
         m_q.delete();
      end else begin
         e_kd    = m_active && (m_q.size() == 0) && (m_pend == 0);
         e_valid = m_active && (m_q.size() > 0) && (m_pend < MP);
         chk("task_valid", 64'(task_valid), 64'(e_valid));
         chk("kernel_done", 64'(kernel_done), 64'(e_kd));
         chk("busy", 64'(busy), 64'(m_active && !e_kd));
         chk("start_ready", 64'(start_ready), 64'(!m_active));
         chk("err_underflow", 64'(err_underflow), 64'(m_err));
         if (e_valid && task_valid) begin
            chk("task_block_idx", 64'(task_block_idx), 64'(m_q[0]));
            chk("task_last", 64'(task_last), 64'(m_q.size() == 1));
            chk("task_pc", 64'(task_pc), 64'(m_pc));
            chk("task_param", 64'(task_param), 64'(m_param));
            chk("task_block_dim", 64'(task_block_dim), 64'(m_bdim));
         end
         hs = 1'b0;
         if (!m_active) begin
            if (start_valid) begin
               m_active = 1'b1;
               m_pc     = start_pc;
               m_param  = start_param;
               m_bdim   = block_dim;
               for (int z = 0; z < int'(grid_dim[47:32]); z++)
                  for (int y = 0; y < int'(grid_dim[31:16]); y++)
                     for (int x = 0; x < int'(grid_dim[15:0]); x++)
                        m_q.push_back({16'(z), 16'(y), 16'(x)});
            end
         end else if (e_kd) begin
            m_active = 1'b0;
            n_kd++;
         end else if (e_valid && task_ready) begin
            hs = 1'b1;
            got.push_back(m_q[0]);
            if (m_q.size() == 1) last_hs = n_hs + 1;
            void'(m_q.pop_front());
            n_hs++;
         end
         if (hs && !task_done) m_pend++;
         else if (!hs && task_done) begin
            if (m_pend == 0) m_err = 1'b1;
            else m_pend--;
         end
      end
   end

   int hs_base, got_base, kd_base;

   task automatic go(input int gz, input int gy, input int gx);
      hs_base  = n_hs;
      got_base = got.size();
      kd_base  = n_kd;
      req_gz = gz; req_gy = gy; req_gx = gx;
      req_seq++;
   endtask

   task automatic wait_done(input string nm, input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         @(posedge clk);
         if (n_kd > kd_base) break;
      end
      if (k >= budget) begin
         n_chk++; n_fail++;
         $display("FAIL %s: no kernel_done within %0d cycles", nm, budget);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      #1;
      chk("rst_start_ready", 64'(start_ready), 64'd1);
      chk("rst_task_valid", 64'(task_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_kernel_done", 64'(kernel_done), 64'd0);
      chk("rst_err", 64'(err_underflow), 64'd0);
      chk("rst_idx", 64'(task_block_idx), 64'd0);
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b1;
      drv_en = 1'b1;

      // 3x2x1 grid, always ready, immediate retire
      go(1, 2, 3);
      wait_done("grid123", 100);
      chk("g123_count", 64'(n_hs - hs_base), 64'd6);
      chk("g123_idx2", 64'(got[got_base + 2]), {16'd0, 16'd0, 16'd2});
      chk("g123_idx3", 64'(got[got_base + 3]), {16'd0, 16'd1, 16'd0});
      chk("g123_idx5", 64'(got[got_base + 5]), {16'd0, 16'd1, 16'd2});
      chk("g123_last", 64'(last_hs - hs_base), 64'd6);

      // stalls with ready pattern 1,0,0
      rmode = 1;
      go(1, 1, 4);
      wait_done("stall", 100);
      chk("stall_count", 64'(n_hs - hs_base), 64'd4);
      chk("stall_idx3", 64'(got[got_base + 3]), {16'd0, 16'd0, 16'd3});
      rmode = 0;

      // throttle at the outstanding limit
      dmode = 1;
      go(1, 1, 5);
      repeat (12) @(posedge clk);
      #3;
      chk("throttle_issued", 64'(n_hs - hs_base), 64'd2);
      chk("throttle_valid", 64'(task_valid), 64'd0);
      dmode = 0;
      wait_done("throttle", 100);
      chk("throttle_total", 64'(n_hs - hs_base), 64'd5);

      // empty grid
      go(1, 1, 0);
      wait_done("zero_grid", 4);
      chk("zero_tasks", 64'(n_hs - hs_base), 64'd0);

      // single block
      go(1, 1, 1);
      wait_done("one_block", 20);
      chk("one_count", 64'(n_hs - hs_base), 64'd1);
      chk("one_last", 64'(last_hs - hs_base), 64'd1);

      // randomized launches with stray start requests
      noise = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rmode = int'($urandom_range(0, 2));
         dmode = ($urandom_range(0, 1) == 0) ? 0 : 2;
         go(int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
         wait_done("random", 600);
      end
      noise = 1'b0;
      rmode = 0;
      dmode = 0;

      // retire with nothing outstanding while idle
      repeat (2) @(posedge clk);
      force_done = 1'b1;
      @(posedge clk);
      force_done = 1'b0;
      repeat (3) @(posedge clk);
      #3 chk("underflow_set", 64'(err_underflow), 64'd1);
      go(1, 1, 2);
      wait_done("after_unf", 50);
      #3 chk("underflow_sticky", 64'(err_underflow), 64'd1);

      // reset in the middle of an 8-block grid
      dmode = 2;
      go(1, 1, 8);
      for (int k = 0; k < 200; k++) begin
         @(posedge clk);
         if (n_hs - hs_base >= 3) break;
      end
      #2;
      drv_en = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(task_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_ready", 64'(start_ready), 64'd1);
      chk("mid_rst_err", 64'(err_underflow), 64'd0);
      chk("mid_rst_idx", 64'(task_block_idx), 64'd0);
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
      #1 chk("post_rst_ready", 64'(start_ready), 64'd1);
      dmode = 0;
      drv_en = 1'b1;
      go(1, 1, 2);
      wait_done("relaunch", 50);
      chk("relaunch_idx0", 64'(got[got_base]), 64'd0);
      chk("relaunch_count", 64'(n_hs - hs_base), 64'd2);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/vx_kmu_dispatch.md
Name: vx_kmu_dispatch

Overview:
- Kernel-launch task dispatcher; initiator (master) side of the KMU task bus that each socket consumes as a slave.
- Accepts one kernel launch (PC, argument pointer, grid and block dims) and walks the grid, emitting one task per block (x fastest, then y, then z).
- Throttles on an outstanding-task limit and counts per-block completions.
- Reports kernel completion once every block has retired; sits between the DCR/launch logic and the cluster-level task arbiter.

Parameters:
- XLEN, 32, width of PC and argument pointer.
- DIM_W, 16, bits per grid/block dimension.
- MAX_PENDING, 64, max issued-but-not-completed tasks (≥1).
- PEND_W, $clog2(MAX_PENDING+1), outstanding counter width (derived).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start_valid  in  1  launch request.
- start_ready  out  1  launch accepted when high with start_valid.
- start_pc  in  XLEN  kernel entry PC.
- start_param  in  XLEN  kernel argument pointer.
- grid_dim  in  3*DIM_W  {z,y,x} grid size in blocks.
- block_dim  in  3*DIM_W  {z,y,x} threads per block; passthrough.
- task_valid  out  1  task present.
- task_ready  in  1  downstream accepts task.
- task_pc  out  XLEN  latched start_pc.
- task_param  out  XLEN  latched start_param.
- task_block_idx  out  3*DIM_W  {z,y,x} block index.
- task_block_dim  out  3*DIM_W  latched block_dim.
- task_last  out  1  final block of the grid.
- task_done  in  1  one-cycle pulse per retired block.
- busy  out  1  launch in progress.
- kernel_done  out  1  one-cycle pulse at completion.
- err_underflow  out  1  sticky; task_done seen with zero outstanding.

Behaviour:
- Reset (async assert, sync deassert inside clk domain): state IDLE.
  - All outputs 0 except start_ready=1.
  - Counters, block index and latched fields cleared.
  - Reset mid-grid abandons the launch; no kernel_done.
- States:
  - IDLE: start_ready=1. On start_valid: latch pc/param/grid/block dims, index=0, go ISSUE. If any grid dim==0, go FIN instead and issue no tasks.
  - ISSUE: start_ready=0, busy=1. task_valid=1 while outstanding<MAX_PENDING.
    - Payload is registered and stable while valid && !ready.
    - On handshake: advance x; on x==gx-1 wrap x=0 and advance y; likewise y→z.
    - task_last=1 when idx=={gz-1,gy-1,gx-1}. A handshake with task_last goes to DRAIN.
  - DRAIN: task_valid=0; wait outstanding==0, then go FIN.
  - FIN: kernel_done=1 for exactly one cycle; next state IDLE. busy=0 in FIN.
- Outstanding counter: +1 per task handshake, −1 per task_done, unchanged when both occur in the same cycle.
  - task_done while outstanding==0 (and no same-cycle issue): counter held at 0, err_underflow set; cleared only by reset.
  - Counter never exceeds MAX_PENDING. At the limit, task_valid deasserts (valid may drop only when no handshake is pending, i.e. it is gated before assertion). A task_done at the limit re-enables task_valid the next cycle.
- task_valid is a registered output; issue throughput is 1 task/cycle when unthrottled.
- A 1×1×1 grid issues one task with task_last=1.
- start_valid in a non-IDLE state is ignored (start_ready=0).
- Index counters are DIM_W wide. Maximum grid 2^DIM_W−1 per dim; no overflow because wrap occurs at g−1.

Test Plan:
- grid {1,2,3}, task_ready=1, immediate done pulses -> 6 tasks, idx order x0y0,x1y0,x2y0,x0y1,x1y1,x2y1; task_last only on 6th; kernel_done one cycle after the last done.
- grid {1,1,4}, task_ready toggling 1,0,0,1… -> payload held stable across stalls; exactly 4 handshakes, no duplicates or skips.
- MAX_PENDING=2, grid {1,1,5}, no task_done until cycle 20 -> task_valid drops after 2 issues; resumes one cycle after each done; total 5 issued.
- grid_dim x=0 -> no task_valid; kernel_done pulses ≤2 cycles after start handshake; busy never set during tasks.
- Same-cycle issue and task_done with outstanding=1 -> outstanding stays 1; task_done at outstanding 0 in IDLE -> err_underflow=1 and sticky.
- reset_n pulled low mid-ISSUE (after 3 of 8 tasks) -> outputs clear asynchronously; start_ready=1 after release; a new launch starts at idx 0.
